seven_segment_scan: RTL and testbench

- Time-multiplexing controller for a bank of common-cathode/anode seven-segment digits on the icoboard.
- Stores one 4-bit value, a decimal point and a blank flag per digit, then scans the digits in turn.
- For each digit it presents the nibble and DP to the single shared seven_segment_case decoder and drives that digit's enable line.
- Writes land in shadow registers and are committed at frame boundaries so no digit ever shows a half-updated frame.

---
 rtl/seven_segment_scan.sv | 155 +++++++++++++++
 tb/tb_seven_segment_scan.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan.sv
// seven_segment_scan: time-multiplexed scan controller for a bank of
// seven-segment digits. Writes land in a shadow bank that is committed to the
// displayed (active) bank only on scan entry and at frame boundaries.
module seven_segment_scan #(
  parameter int NUM_DIGITS       = 4,
  parameter int DWELL_CYCLES     = 12000,
  parameter int BLANK_CYCLES     = 16,
  parameter int DIGIT_ACTIVE_LOW = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
  input  logic [5:0]                    wr_data,
  output logic [3:0]                    seg_bin,
  output logic                          seg_dp,
  output logic [NUM_DIGITS-1:0]         digit_en,
  output logic                          frame_done
);

  localparam int unsigned AW   = $clog2(NUM_DIGITS);
  localparam int unsigned CMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [AW-1:0] IDX_LAST   = AW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] EN_OFF = {NUM_DIGITS{DIGIT_ACTIVE_LOW != 0}};
  localparam logic [5:0] ENTRY_BLANKED = 6'b100000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_SHOW
  } state_e;

  state_e                  state_q, state_d;
  logic [AW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [5:0]              shadow_q [NUM_DIGITS];
  logic [5:0]              shadow_d [NUM_DIGITS];
  logic [5:0]              active_q [NUM_DIGITS];
  logic [5:0]              active_d [NUM_DIGITS];
  logic                    commit;
  logic [3:0]              seg_bin_q, seg_bin_d;
  logic                    seg_dp_q, seg_dp_d;
  logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
  logic [NUM_DIGITS-1:0]   onehot;
  logic                    frame_done_q, frame_done_d;

  // Shadow writes, scan sequencing and frame-boundary commit
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    commit   = 1'b0;

    if (wr_en && (32'(wr_addr) < 32'(NUM_DIGITS))) begin
      shadow_d[wr_addr] = wr_data;
    end

    if (!enable) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = (BLANK_CYCLES > 0) ? S_BLANK : S_SHOW;
          idx_d   = '0;
          cnt_d   = '0;
          commit  = 1'b1;
        end
        S_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = S_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_SHOW: begin
          if (cnt_q == DWELL_LAST) begin
            state_d = (BLANK_CYCLES > 0) ? S_BLANK : S_SHOW;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d  = '0;
              commit = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Commit takes the post-write shadow so a same-cycle write is included
    if (commit) begin
      active_d = shadow_d;
    end
  end

  // Registered outputs are derived from next-state values so they line up
  // with the state they describe rather than lagging by one cycle
  always_comb begin
    onehot        = '0;
    onehot[idx_d] = 1'b1;
    seg_bin_d     = '0;
    seg_dp_d      = 1'b0;
    if (state_d != S_IDLE) begin
      seg_bin_d = active_d[idx_d][3:0];
      seg_dp_d  = active_d[idx_d][4];
    end
    digit_en_d   = ((state_d == S_SHOW) && !active_d[idx_d][5]) ? onehot : '0;
    digit_en_d   = digit_en_d ^ EN_OFF;
    frame_done_d = (state_d == S_SHOW) && (idx_d == IDX_LAST) && (cnt_d == DWELL_LAST);
  end

  // State, storage and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      shadow_q     <= '{default: ENTRY_BLANKED};
      active_q     <= '{default: ENTRY_BLANKED};
      seg_bin_q    <= '0;
      seg_dp_q     <= 1'b0;
      digit_en_q   <= EN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      seg_bin_q    <= seg_bin_d;
      seg_dp_q     <= seg_dp_d;
      digit_en_q   <= digit_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_bin    = seg_bin_q;
  assign seg_dp     = seg_dp_q;
  assign digit_en   = digit_en_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Bench for seven_segment_scan: two configurations driven by shared inputs,
// checked against a timeline model (cycles since scan start -> slot/phase).
module tb_seven_segment_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [5:0] wr_data = '0;

  logic [3:0] seg_bin0, seg_bin1;
  logic       seg_dp0, seg_dp1, fd0, fd1;
  logic [3:0] den0;
  logic [2:0] den1;

  always #5 clk = ~clk;

  seven_segment_scan #(
    .NUM_DIGITS(4), .DWELL_CYCLES(4), .BLANK_CYCLES(2), .DIGIT_ACTIVE_LOW(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .seg_bin(seg_bin0),
    .seg_dp(seg_dp0), .digit_en(den0), .frame_done(fd0)
  );

  seven_segment_scan #(
    .NUM_DIGITS(3), .DWELL_CYCLES(3), .BLANK_CYCLES(0), .DIGIT_ACTIVE_LOW(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .seg_bin(seg_bin1),
    .seg_dp(seg_dp1), .digit_en(den1), .frame_done(fd1)
  );

  int checks = 0;
  int errors = 0;
  string phase = "init";

  // Model configuration per DUT
  int mn[2]  = '{4, 3};
  int md[2]  = '{4, 3};
  int mb[2]  = '{2, 0};
  int mal[2] = '{0, 1};

  // Model state: shadow/displayed values, running flag, cycles since scan start
  logic [5:0] sh[2][8];
  logic [5:0] ac[2][8];
  bit         run[2];
  int         t[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        sh[k][i] = 6'h20;
        ac[k][i] = 6'h20;
      end
      run[k] = 1'b0;
      t[k]   = 0;
    end
  endtask

  // One clock edge of the model, using the inputs present at that edge
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int p;
      p = mn[k] * (mb[k] + md[k]);
      if (wr_en && (int'(wr_addr) < mn[k])) sh[k][wr_addr] = wr_data;
      if (!enable) begin
        run[k] = 1'b0;
        t[k]   = 0;
      end else if (!run[k]) begin
        run[k] = 1'b1;
        t[k]   = 0;
        for (int i = 0; i < 8; i++) ac[k][i] = sh[k][i];
      end else begin
        if (t[k] % p == p - 1) begin
          for (int i = 0; i < 8; i++) ac[k][i] = sh[k][i];
        end
        t[k]++;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] es, ed, ee, ef, gs, gd, ge, gf;
      es = 0; ed = 0; ee = 0; ef = 0;
      if (run[k]) begin
        int sl, p, slot, pos;
        logic [5:0] e;
        sl   = mb[k] + md[k];
        p    = mn[k] * sl;
        slot = (t[k] / sl) % mn[k];
        pos  = t[k] % sl;
        e    = ac[k][slot];
        es   = 32'(e[3:0]);
        ed   = 32'(e[4]);
        ee   = (pos >= mb[k] && !e[5]) ? (32'd1 << slot) : 32'd0;
        ef   = (t[k] % p == p - 1) ? 32'd1 : 32'd0;
      end
      if (mal[k] != 0) ee = ee ^ ((32'd1 << mn[k]) - 32'd1);
      if (k == 0) begin
        gs = 32'(seg_bin0); gd = 32'(seg_dp0); ge = 32'(den0); gf = 32'(fd0);
      end else begin
        gs = 32'(seg_bin1); gd = 32'(seg_dp1); ge = 32'(den1); gf = 32'(fd1);
      end
      chk($sformatf("%s.d%0d.seg_bin", phase, k), gs, es);
      chk($sformatf("%s.d%0d.seg_dp", phase, k), gd, ed);
      chk($sformatf("%s.d%0d.digit_en", phase, k), ge, ee);
      chk($sformatf("%s.d%0d.frame_done", phase, k), gf, ef);
    end
  endtask

  task automatic step(input bit en, input bit we, input int a, input logic [5:0] d);
    enable  = en;
    wr_en   = we;
    wr_addr = a[1:0];
    wr_data = d;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 6'h00);
  endtask

  initial begin
    bit found;

    // Reset asserted before the first clock edge
    model_reset();
    #2 rst_n = 1'b0;
    #1 phase = "reset";
    check_all();
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk) rst_n = 1'b1;
    #4;

    // Disabled: everything stays off
    phase = "idle";
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 6'h00);

    // Load 1..4 while idle (addr 3 is out of range for the 3-digit DUT)
    phase = "load";
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, i, 6'(i + 1));

    phase = "scan";
    run_idle(30);

    // Mid-frame write while digit 2 is lit
    phase = "wait_d2";
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (den0 == 4'b0100) found = 1'b1;
      else step(1'b1, 1'b0, 0, 6'h00);
    end
    chk("wait_digit2", 32'(found), 32'd1);
    phase = "midwrite";
    step(1'b1, 1'b1, 0, 6'h09);
    run_idle(30);

    // Write during the frame_done cycle lands in the very next frame
    phase = "wait_fd";
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (fd0 == 1'b1) found = 1'b1;
      else step(1'b1, 1'b0, 0, 6'h00);
    end
    chk("wait_frame_done", 32'(found), 32'd1);
    phase = "fdwrite";
    step(1'b1, 1'b1, 2, 6'h0c);
    run_idle(30);

    // Blanked digit with DP set keeps its slot dark
    phase = "blankdig";
    step(1'b1, 1'b1, 1, 6'b110101);
    run_idle(50);

    // Drop enable while digit 2 is lit, then restart
    phase = "wait_d2b";
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (den0 == 4'b0100) found = 1'b1;
      else step(1'b1, 1'b0, 0, 6'h00);
    end
    chk("wait_digit2_drop", 32'(found), 32'd1);
    phase = "drop";
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 6'h00);
    phase = "restart";
    run_idle(30);

    // Random traffic with occasional enable drops
    phase = "rand";
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 19) != 0, $urandom_range(0, 2) == 0,
           int'($urandom_range(0, 3)), 6'($urandom_range(0, 63)));
    end

    // Asynchronous reset in the middle of a slot
    phase = "pre_arst";
    run_idle(7);
    #2 rst_n = 1'b0;
    model_reset();
    #1 phase = "async_rst";
    check_all();
    @(negedge clk) rst_n = 1'b1;
    #4;
    phase = "post_rst";
    for (int i = 0; i < 60; i++) begin
      step(1'b1, $urandom_range(0, 3) == 0,
           int'($urandom_range(0, 3)), 6'($urandom_range(0, 31)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
